// File: rtl/bls12_381_data_ram_arb_if.sv
// Bus bundle for the bls12-381 data RAM arbiter: host and engine request
// channels, the shared RAM port and the grant statistics.
// slave  : the arbiter side.
// master : the environment side (requesters and RAM).
interface bls12_381_data_ram_arb_if #(
  parameter int unsigned ADR_W = 12,
  parameter int unsigned DAT_W = 384
);
  // Host channel
  logic             i_h_req;
  logic             i_h_we;
  logic [ADR_W-1:0] i_h_a;
  logic [DAT_W-1:0] i_h_d;
  logic             o_h_gnt;
  logic [DAT_W-1:0] o_h_q;
  logic             o_h_qval;
  // Engine channel
  logic             i_e_req;
  logic             i_e_we;
  logic [ADR_W-1:0] i_e_a;
  logic [DAT_W-1:0] i_e_d;
  logic             o_e_gnt;
  logic [DAT_W-1:0] o_e_q;
  logic             o_e_qval;
  // RAM port
  logic             o_ram_en;
  logic             o_ram_we;
  logic             o_ram_re;
  logic [ADR_W-1:0] o_ram_a;
  logic [DAT_W-1:0] o_ram_d;
  logic [DAT_W-1:0] i_ram_q;
  // Statistics
  logic [31:0]      o_h_gnt_cnt;
  logic [31:0]      o_e_gnt_cnt;

  modport slave (
    input  i_h_req, i_h_we, i_h_a, i_h_d,
    output o_h_gnt, o_h_q, o_h_qval,
    input  i_e_req, i_e_we, i_e_a, i_e_d,
    output o_e_gnt, o_e_q, o_e_qval,
    output o_ram_en, o_ram_we, o_ram_re, o_ram_a, o_ram_d,
    input  i_ram_q,
    output o_h_gnt_cnt, o_e_gnt_cnt
  );

  modport master (
    output i_h_req, i_h_we, i_h_a, i_h_d,
    input  o_h_gnt, o_h_q, o_h_qval,
    output i_e_req, i_e_we, i_e_a, i_e_d,
    input  o_e_gnt, o_e_q, o_e_qval,
    input  o_ram_en, o_ram_we, o_ram_re, o_ram_a, o_ram_d,
    output i_ram_q,
    input  o_h_gnt_cnt, o_e_gnt_cnt
  );
endinterface

// File: rtl/bls12_381_data_ram_arb.sv
// Single-port data RAM arbiter for the bls12-381 coprocessor.
// Engine has priority; a saturating wait counter forces a host grant after
// MAX_WAIT consecutive denied host cycles. The winning command is registered
// onto the RAM port and read data is steered back to its issuer through a
// READ_CYC-deep {valid, owner} tag pipeline.
// Optional macro: BLS12_381_DATA_RAM_ARB_STATS_EN enables saturating grant
// counters; when undefined both counter outputs are tied to zero.
module bls12_381_data_ram_arb #(
  parameter int unsigned ADR_W    = 12,
  parameter int unsigned DAT_W    = 384,
  parameter int unsigned READ_CYC = 2,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  bls12_381_data_ram_arb_if.slave   bus
);

  localparam int unsigned WC_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                force_h;
  logic                h_gnt, e_gnt;

  logic                ram_en_q, ram_we_q, ram_re_q, ram_own_q;
  logic [ADR_W-1:0]    ram_a_q;
  logic [DAT_W-1:0]    ram_d_q;

  logic [READ_CYC-1:0] tag_vld_q, tag_own_q;
  logic                tail_vld, tail_own;

  logic [DAT_W-1:0]    h_q_q, e_q_q;
  logic                h_qval_q, e_qval_q;

  // Arbitration and next wait count; grants are suppressed during reset
  always_comb begin
    force_h = (wait_cnt_q == WC_W'(MAX_WAIT));
    h_gnt   = ~i_rst & bus.i_h_req & (force_h | ~bus.i_e_req);
    e_gnt   = ~i_rst & bus.i_e_req & ~h_gnt;
    if (~bus.i_h_req | h_gnt) begin
      wait_cnt_d = '0;
    end else if (force_h) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Host starvation counter
  always_ff @(posedge i_clk) begin
    if (i_rst) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  // Register the winning command onto the RAM port; address/data hold when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_re_q  <= 1'b0;
      ram_own_q <= 1'b0;
      ram_a_q   <= '0;
      ram_d_q   <= '0;
    end else begin
      ram_en_q  <= h_gnt | e_gnt;
      ram_we_q  <= h_gnt ? bus.i_h_we  : (e_gnt & bus.i_e_we);
      ram_re_q  <= h_gnt ? ~bus.i_h_we : (e_gnt & ~bus.i_e_we);
      ram_own_q <= h_gnt;
      if (h_gnt) begin
        ram_a_q <= bus.i_h_a;
        ram_d_q <= bus.i_h_d;
      end else if (e_gnt) begin
        ram_a_q <= bus.i_e_a;
        ram_d_q <= bus.i_e_d;
      end
    end
  end

  // Tag pipeline tracking in-flight reads; stage 0 captures the read on the port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q[0] <= ram_re_q;
      tag_own_q[0] <= ram_own_q;
      for (int unsigned i = 1; i < READ_CYC; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  assign tail_vld = tag_vld_q[READ_CYC-1];
  assign tail_own = tag_own_q[READ_CYC-1];

  // Capture RAM data for the owner of the read at the pipeline tail
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q_q    <= '0;
      e_q_q    <= '0;
      h_qval_q <= 1'b0;
      e_qval_q <= 1'b0;
    end else begin
      h_qval_q <= tail_vld & tail_own;
      e_qval_q <= tail_vld & ~tail_own;
      if (tail_vld & tail_own)  h_q_q <= bus.i_ram_q;
      if (tail_vld & ~tail_own) e_q_q <= bus.i_ram_q;
    end
  end

  assign bus.o_h_gnt  = h_gnt;
  assign bus.o_e_gnt  = e_gnt;
  assign bus.o_ram_en = ram_en_q;
  assign bus.o_ram_we = ram_we_q;
  assign bus.o_ram_re = ram_re_q;
  assign bus.o_ram_a  = ram_a_q;
  assign bus.o_ram_d  = ram_d_q;
  assign bus.o_h_q    = h_q_q;
  assign bus.o_e_q    = e_q_q;
  assign bus.o_h_qval = h_qval_q;
  assign bus.o_e_qval = e_qval_q;

`ifdef BLS12_381_DATA_RAM_ARB_STATS_EN
  logic [31:0] h_cnt_q, e_cnt_q;

  // Saturating grant counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      e_cnt_q <= '0;
    end else begin
      if (h_gnt && (h_cnt_q != '1)) h_cnt_q <= h_cnt_q + 32'd1;
      if (e_gnt && (e_cnt_q != '1)) e_cnt_q <= e_cnt_q + 32'd1;
    end
  end

  assign bus.o_h_gnt_cnt = h_cnt_q;
  assign bus.o_e_gnt_cnt = e_cnt_q;
`else
  assign bus.o_h_gnt_cnt = '0;
  assign bus.o_e_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_bls12_381_data_ram_arb.sv
// Bench for bls12_381_data_ram_arb: directed scenarios plus randomized
// host/engine traffic, a behavioural RAM, a reference arbitration/memory model
// feeding per-requester response queues, and a monitor draining them.
module tb_bls12_381_data_ram_arb;
  localparam int unsigned ADR_W    = 12;
  localparam int unsigned DAT_W    = 384;
  localparam int unsigned READ_CYC = 2;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned NA       = 16;

  typedef logic [DAT_W-1:0] dat_t;
  typedef struct { dat_t d; int due; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bls12_381_data_ram_arb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  bls12_381_data_ram_arb #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .READ_CYC(READ_CYC), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic dat_t init_word(input int a);
    dat_t r;
    for (int i = 0; i < DAT_W / 32; i++) r[i*32 +: 32] = 32'h5EED_0000 | a;
    if (a == 5) r = dat_t'(16'hABCD);
    return r;
  endfunction

  function automatic dat_t rnd_dat();
    dat_t r;
    for (int i = 0; i < DAT_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input dat_t act, input dat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural RAM ----------------
  dat_t          ram_mem [NA];
  logic [NA-1:0] ram_wr = '0;
  dat_t          rd_pipe [READ_CYC];
  logic [3:0]    ram_idx;
  assign ram_idx = bus.o_ram_a[3:0];

  always @(posedge clk) begin
    for (int i = READ_CYC - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= ram_wr[ram_idx] ? ram_mem[ram_idx] : init_word(int'(ram_idx));
    if (bus.o_ram_en && bus.o_ram_we) begin
      ram_mem[ram_idx] <= bus.o_ram_d;
      ram_wr[ram_idx]  <= 1'b1;
    end
  end
  assign bus.i_ram_q = rd_pipe[READ_CYC-1];

  // ---------------- reference model ----------------
  dat_t             ref_mem [NA];
  rsp_t             hq[$];
  rsp_t             eq[$];
  int               m_wait = 0;
  int               m_hcnt = 0;
  int               m_ecnt = 0;
  bit               m_hg, m_eg, armed = 0, rst_prev = 0;
  bit               x_en = 0, x_we = 0;
  logic [ADR_W-1:0] x_a = '0;
  dat_t             x_d = '0;
  rsp_t             r;

  initial for (int i = 0; i < NA; i++) ref_mem[i] = init_word(i);

  // Predict grants from the arbitration rules, then the RAM command and responses
  always @(negedge clk) begin
    if (armed) begin
      chk("ram_en", dat_t'(bus.o_ram_en), dat_t'(x_en));
      chk("ram_we", dat_t'(bus.o_ram_we), dat_t'(x_en & x_we));
      chk("ram_re", dat_t'(bus.o_ram_re), dat_t'(x_en & ~x_we));
      chk("ram_a",  dat_t'(bus.o_ram_a),  dat_t'(x_a));
      chk("ram_d",  bus.o_ram_d, x_d);
      if (rst_prev) begin
        chk("rst_h_q",    bus.o_h_q, '0);
        chk("rst_e_q",    bus.o_e_q, '0);
        chk("rst_h_qval", dat_t'(bus.o_h_qval), '0);
        chk("rst_e_qval", dat_t'(bus.o_e_qval), '0);
      end
    end
    if (rst) begin
      m_hg = 0;
      m_eg = 0;
    end else begin
      m_hg = bus.i_h_req && (m_wait == MAX_WAIT || !bus.i_e_req);
      m_eg = bus.i_e_req && !m_hg;
    end
    chk("h_gnt", dat_t'(bus.o_h_gnt), dat_t'(m_hg));
    chk("e_gnt", dat_t'(bus.o_e_gnt), dat_t'(m_eg));
    if (rst) begin
      m_wait = 0; m_hcnt = 0; m_ecnt = 0;
      hq.delete(); eq.delete();
      x_en = 0; x_we = 0; x_a = '0; x_d = '0;
      armed = 1;
    end else begin
      if (bus.i_h_req && !m_hg) m_wait = (m_wait == MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      else                      m_wait = 0;
      x_en = m_hg | m_eg;
      if (m_hg) begin
        x_we = bus.i_h_we; x_a = bus.i_h_a; x_d = bus.i_h_d; m_hcnt++;
      end else if (m_eg) begin
        x_we = bus.i_e_we; x_a = bus.i_e_a; x_d = bus.i_e_d; m_ecnt++;
      end else begin
        x_we = 0;
      end
      if (x_en) begin
        if (x_we) ref_mem[x_a[3:0]] = x_d;
        else begin
          r.d = ref_mem[x_a[3:0]];
          r.due = cyc + READ_CYC + 2;
          if (m_hg) hq.push_back(r); else eq.push_back(r);
        end
      end
    end
    rst_prev = rst;
  end

  // ---------------- monitor ----------------
  rsp_t mh, me;
  always @(negedge clk) begin
    if (bus.o_h_qval) begin
      if (hq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL h_qval_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        mh = hq.pop_front();
        chk("h_q", bus.o_h_q, mh.d);
        chk("h_qval_cycle", dat_t'(cyc), dat_t'(mh.due));
      end
    end else if (hq.size() != 0 && hq[0].due <= cyc) begin
      mh = hq.pop_front();
      chk("h_qval_missing", dat_t'(bus.o_h_qval), dat_t'(1));
    end
    if (bus.o_e_qval) begin
      if (eq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL e_qval_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        me = eq.pop_front();
        chk("e_q", bus.o_e_q, me.d);
        chk("e_qval_cycle", dat_t'(cyc), dat_t'(me.due));
      end
    end else if (eq.size() != 0 && eq[0].due <= cyc) begin
      me = eq.pop_front();
      chk("e_qval_missing", dat_t'(bus.o_e_qval), dat_t'(1));
    end
  end

  // ---------------- drivers (entered/left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic h_issue(input bit we, input int a, input dat_t d, output int waited);
    bit g = 0;
    bus.i_h_req = 1; bus.i_h_we = we; bus.i_h_a = ADR_W'(a); bus.i_h_d = d;
    waited = 0;
    for (int k = 0; k < 200 && !g; k++) begin
      @(negedge clk);
      if (bus.o_h_gnt) g = 1; else waited++;
    end
    if (!g) begin n_cmp++; n_err++; $display("FAIL h_gnt_timeout cyc=%0d", cyc); end
    @(posedge clk); #1;
    bus.i_h_req = 0;
  endtask

  task automatic e_issue(input bit we, input int a, input dat_t d);
    bit g = 0;
    bus.i_e_req = 1; bus.i_e_we = we; bus.i_e_a = ADR_W'(a); bus.i_e_d = d;
    for (int k = 0; k < 200 && !g; k++) begin
      @(negedge clk);
      if (bus.o_e_gnt) g = 1;
    end
    if (!g) begin n_cmp++; n_err++; $display("FAIL e_gnt_timeout cyc=%0d", cyc); end
    @(posedge clk); #1;
    bus.i_e_req = 0;
  endtask

  int w;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_h_req = 0; bus.i_h_we = 0; bus.i_h_a = '0; bus.i_h_d = '0;
    bus.i_e_req = 0; bus.i_e_we = 0; bus.i_e_a = '0; bus.i_e_d = '0;
    rst = 1;
    idle(3);
    rst = 0;

    // Grant statistics: 5 host, 7 engine
    for (int i = 0; i < 5; i++) h_issue(1, 8 + i, rnd_dat(), w);
    for (int i = 0; i < 7; i++) e_issue(1, 8 + i, rnd_dat());
    idle(2);
`ifdef BLS12_381_DATA_RAM_ARB_STATS_EN
    chk("h_gnt_cnt_5", dat_t'(bus.o_h_gnt_cnt), dat_t'(5));
    chk("e_gnt_cnt_7", dat_t'(bus.o_e_gnt_cnt), dat_t'(7));
`else
    chk("h_gnt_cnt_off", dat_t'(bus.o_h_gnt_cnt), '0);
    chk("e_gnt_cnt_off", dat_t'(bus.o_e_gnt_cnt), '0);
`endif

    // Host-only read of address 5 (holds 0xABCD)
    h_issue(0, 5, '0, w);
    idle(8);

    // Engine every cycle, host holds a read: host waits exactly MAX_WAIT cycles
    fork
      for (int i = 0; i < 12; i++) e_issue(1, $urandom_range(0, 15), rnd_dat());
      begin h_issue(0, 6, '0, w); chk("host_wait_cycles", dat_t'(w), dat_t'(MAX_WAIT)); end
    join
    idle(8);

    // Host request withdrawn before grant has no side effects
    fork
      for (int i = 0; i < 6; i++) e_issue(0, i, '0);
      begin
        bus.i_h_req = 1; bus.i_h_we = 1; bus.i_h_a = ADR_W'(2); bus.i_h_d = rnd_dat();
        idle(3);
        bus.i_h_req = 0;
      end
    join
    idle(8);

    // Simultaneous first requests: engine write wins, host reads it back
    fork
      e_issue(1, 3, dat_t'(16'h1234));
      h_issue(0, 3, '0, w);
    join
    idle(8);

    // Interleaved reads E, H, E on consecutive cycles
    e_issue(0, 1, '0);
    h_issue(0, 2, '0, w);
    e_issue(0, 3, '0);
    idle(8);

    // Reset one cycle after a host read grant: the read must never return
    h_issue(0, 5, '0, w);
    rst = 1;
    idle(3);
    rst = 0;
    idle(8);

    // Randomized mixed traffic
    fork
      for (int i = 0; i < 300; i++) begin
        idle($urandom_range(0, 3));
        h_issue($urandom_range(0, 1) == 1, $urandom_range(0, 15), rnd_dat(), w);
      end
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        e_issue($urandom_range(0, 1) == 1, $urandom_range(0, 15), rnd_dat());
      end
    join
    idle(12);

    chk("h_queue_drained", dat_t'(hq.size()), '0);
    chk("e_queue_drained", dat_t'(eq.size()), '0);
`ifdef BLS12_381_DATA_RAM_ARB_STATS_EN
    chk("h_gnt_cnt_final", dat_t'(bus.o_h_gnt_cnt), dat_t'(m_hcnt));
    chk("e_gnt_cnt_final", dat_t'(bus.o_e_gnt_cnt), dat_t'(m_ecnt));
`else
    chk("h_gnt_cnt_final", dat_t'(bus.o_h_gnt_cnt), '0);
    chk("e_gnt_cnt_final", dat_t'(bus.o_e_gnt_cnt), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
